// File: rtl/efc_rd_ctl_pkg.sv
// rtl/efc_rd_ctl_pkg.sv - shared efuse read-controller widths and FSM encodings
package efc_rd_ctl_pkg;

  localparam int EFC_ROW_W   = 7;
  localparam int EFC_DATA_W  = 32;
  localparam int EFC_ACC_CYC = 4;
  localparam int EFC_COL_W   = 5;
  // Wide enough for any practical array access time.
  localparam int EFC_WAIT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } efc_rd_state_e;

endpackage

// File: rtl/efc_rd_cnt.sv
// rtl/efc_rd_cnt.sv - column counter and access-wait down-counter for the efuse read walk
module efc_rd_cnt
  import efc_rd_ctl_pkg::*;
#(
  parameter int DATA_W  = EFC_DATA_W,
  parameter int ACC_CYC = EFC_ACC_CYC
) (
  input  logic                 clk,
  input  logic                 arst_l,
  input  logic                 col_clr,
  input  logic                 col_inc,
  input  logic                 wait_ld,
  input  logic                 wait_dec,
  output logic [EFC_COL_W-1:0] col,
  output logic                 col_last,
  output logic                 wait_zero
);

  // Load value makes WAIT last ACC_CYC-1 cycles (values ACC_CYC-2 down to 0).
  localparam logic [EFC_WAIT_W-1:0] WAIT_LD_VAL = EFC_WAIT_W'(ACC_CYC - 2);
  localparam logic [EFC_COL_W-1:0]  COL_LAST    = EFC_COL_W'(DATA_W - 1);

  logic [EFC_WAIT_W-1:0] wait_cnt;

  // Column address: cleared on accept, advanced after each non-final sample.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      col <= '0;
    end else if (col_clr) begin
      col <= '0;
    end else if (col_inc) begin
      col <= col + 1'b1;
    end
  end

  // Access wait counter: loaded on the strobe, counts down while waiting.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      wait_cnt <= '0;
    end else if (wait_ld) begin
      wait_cnt <= WAIT_LD_VAL;
    end else if (wait_dec && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign col_last  = (col == COL_LAST);
  assign wait_zero = (wait_cnt == '0);

endmodule

// File: rtl/efc_rd_ctl.sv
// rtl/efc_rd_ctl.sv - efuse row read sequencer feeding the JTAG capture word
module efc_rd_ctl
  import efc_rd_ctl_pkg::*;
#(
  parameter int ROW_W   = EFC_ROW_W,
  parameter int DATA_W  = EFC_DATA_W,
  parameter int ACC_CYC = EFC_ACC_CYC
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic              rd_req,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic              fuse_dout,
  output logic [ROW_W-1:0]  efc_fuse_row,
  output logic [4:0]        efc_fuse_col,
  output logic              efc_fuse_rd_en,
  output logic [DATA_W-1:0] read_data_ff,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              rd_ovfl
);

  efc_rd_state_e state, state_nxt;

  logic              col_clr, col_inc, wait_ld, wait_dec;
  logic              col_last, wait_zero;
  logic              accept, sample_en;
  logic [DATA_W-1:0] asm_q, asm_nxt;

  efc_rd_cnt #(
    .DATA_W  (DATA_W),
    .ACC_CYC (ACC_CYC)
  ) u_cnt (
    .clk       (clk),
    .arst_l    (arst_l),
    .col_clr   (col_clr),
    .col_inc   (col_inc),
    .wait_ld   (wait_ld),
    .wait_dec  (wait_dec),
    .col       (efc_fuse_col),
    .col_last  (col_last),
    .wait_zero (wait_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one strobe/wait/sample round per column until the last one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rd_req) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: state_nxt = ST_WAIT;
      ST_WAIT:   if (wait_zero) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = col_last ? ST_DONE : ST_STROBE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-state controls and status outputs.
  always_comb begin
    efc_fuse_rd_en = (state == ST_STROBE);
    rd_busy        = (state != ST_IDLE);
    rd_done        = (state == ST_DONE);
    accept         = (state == ST_IDLE) && rd_req;
    sample_en      = (state == ST_SAMPLE);
    col_clr        = accept;
    col_inc        = sample_en && !col_last;
    wait_ld        = (state == ST_STROBE);
    wait_dec       = (state == ST_WAIT);
  end

  // Assembly word including the bit being sampled this cycle, so the final
  // column lands in read_data_ff on the same edge that enters DONE.
  always_comb begin
    asm_nxt               = asm_q;
    asm_nxt[efc_fuse_col] = fuse_dout;
  end

  // Row latch, bit assembly and the committed word; only a full walk updates read_data_ff.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      efc_fuse_row <= '0;
      asm_q        <= '0;
      read_data_ff <= '0;
    end else begin
      if (accept) begin
        efc_fuse_row <= rd_row;
        asm_q        <= '0;
      end else if (sample_en) begin
        asm_q <= asm_nxt;
      end
      if (sample_en && col_last) begin
        read_data_ff <= asm_nxt;
      end
    end
  end

  // Sticky overflow: a request that arrives while busy is dropped and flagged.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      rd_ovfl <= 1'b0;
    end else if (accept) begin
      rd_ovfl <= 1'b0;
    end else if (rd_req && rd_busy) begin
      rd_ovfl <= 1'b1;
    end
  end

endmodule

// File: tb/tb_efc_rd_ctl.sv
// tb/tb_efc_rd_ctl.sv - directed self-checking bench for efc_rd_ctl
module tb_efc_rd_ctl;

  logic        clk = 1'b0;
  logic        arst_l;
  logic        rd_req, rd_req2;
  logic [6:0]  rd_row, rd_row2;
  logic        fuse_dout, fuse_dout2;
  logic [6:0]  row, row2;
  logic [4:0]  col, col2;
  logic        rd_en, rd_en2;
  logic [31:0] rdata, rdata2;
  logic        busy, busy2, done, done2, ovfl, ovfl2;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  efc_rd_ctl u_dut (
    .clk(clk), .arst_l(arst_l), .rd_req(rd_req), .rd_row(rd_row), .fuse_dout(fuse_dout),
    .efc_fuse_row(row), .efc_fuse_col(col), .efc_fuse_rd_en(rd_en), .read_data_ff(rdata),
    .rd_busy(busy), .rd_done(done), .rd_ovfl(ovfl)
  );

  efc_rd_ctl #(.ACC_CYC(2)) u_dut2 (
    .clk(clk), .arst_l(arst_l), .rd_req(rd_req2), .rd_row(rd_row2), .fuse_dout(fuse_dout2),
    .efc_fuse_row(row2), .efc_fuse_col(col2), .efc_fuse_rd_en(rd_en2), .read_data_ff(rdata2),
    .rd_busy(busy2), .rd_done(done2), .rd_ovfl(ovfl2)
  );

  // Array models: data is valid only in the cycle ACC_CYC after the strobe, X otherwise.
  logic [31:0] pat, pat2;
  int pend = 0, mcol = 0, pend2 = 0, mcol2 = 0;

  always @(negedge clk) begin
    if (rd_en) begin
      pend = 4; mcol = int'(col); fuse_dout = 1'bx;
    end else if (pend > 0) begin
      pend--; fuse_dout = (pend == 0) ? pat[mcol] : 1'bx;
    end else begin
      fuse_dout = 1'bx;
    end
  end

  always @(negedge clk) begin
    if (rd_en2) begin
      pend2 = 2; mcol2 = int'(col2); fuse_dout2 = 1'bx;
    end else if (pend2 > 0) begin
      pend2--; fuse_dout2 = (pend2 == 0) ? pat2[mcol2] : 1'bx;
    end else begin
      fuse_dout2 = 1'bx;
    end
  end

  // Strobe / done / stability monitors.
  int strobes = 0, col_bad = 0, row_bad = 0, dones = 0, chg = 0;
  int strobes2 = 0, gap_bad = 0, last_strobe2 = -1;
  logic [6:0]  exp_row;
  logic [31:0] prev_rd = '0;

  always @(negedge clk) begin
    if (rd_en) begin
      if (col !== 5'(strobes)) col_bad++;
      if (row !== exp_row) row_bad++;
      strobes++;
    end
    if (done) dones++;
    if (arst_l && busy && !done && (rdata !== prev_rd)) chg++;
    prev_rd = rdata;
    if (rd_en2) begin
      if (last_strobe2 >= 0 && strobes2 > 0 && (cyc - last_strobe2) != 3) gap_bad++;
      last_strobe2 = cyc;
      strobes2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int req_cyc;

  task automatic start1(input logic [6:0] r, input logic [31:0] p);
    @(negedge clk);
    pat = p; exp_row = r; strobes = 0; col_bad = 0; row_bad = 0;
    rd_row = r; rd_req = 1'b1;
    @(posedge clk);
    #1;
    req_cyc = cyc;
    rd_req = 1'b0;
  endtask

  task automatic wait1(output int lat);
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - req_cyc;
        break;
      end
    end
  endtask

  int lat, done_a, d0, r2;

  initial begin
    arst_l = 1'b0; rd_req = 1'b0; rd_row = '0; rd_req2 = 1'b0; rd_row2 = '0;
    exp_row = '0; pat = '0; pat2 = '0;
    #1;
    check("rst_row", 32'(row), 32'h0);
    check("rst_col", 32'(col), 32'h0);
    check("rst_data", rdata, 32'h0);
    check("rst_flags", {28'h0, busy, done, ovfl, rd_en}, 32'h0);
    repeat (3) @(negedge clk);
    arst_l = 1'b1;

    // 1: basic read, row 0x05
    start1(7'h05, 32'hA5A5_0F0F);
    check("t1_busy", 32'(busy), 32'h1);
    repeat (20) @(negedge clk);
    check("t1_data_hold", rdata, 32'h0);
    wait1(lat);
    check("t1_latency", 32'(lat), 32'd161);
    check("t1_data", rdata, 32'hA5A5_0F0F);
    check("t1_strobes", 32'(strobes), 32'd32);
    check("t1_col_seq", 32'(col_bad), 32'd0);
    check("t1_row_held", 32'(row_bad), 32'd0);
    @(negedge clk);
    check("t1_idle", {30'h0, busy, done}, 32'h0);

    // 2: request while busy sets the sticky overflow and is dropped
    start1(7'h11, 32'h1357_9BDF);
    d0 = dones;
    repeat (20) @(negedge clk);
    rd_row = 7'h22; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("t2_ovfl_set", 32'(ovfl), 32'h1);
    wait1(lat);
    check("t2_latency", 32'(lat), 32'd161);
    check("t2_data", rdata, 32'h1357_9BDF);
    repeat (10) @(negedge clk);
    check("t2_one_done", 32'(dones - d0), 32'd1);
    check("t2_strobes", 32'(strobes), 32'd32);
    check("t2_row_held", 32'(row_bad), 32'd0);
    check("t2_ovfl_sticky", 32'(ovfl), 32'h1);

    // 3: next accepted request clears overflow; then a back-to-back read
    start1(7'h44, 32'h0123_4567);
    check("t3_ovfl_clr", 32'(ovfl), 32'h0);
    wait1(lat);
    done_a = cyc;
    check("t3a_data", rdata, 32'h0123_4567);
    start1(7'h7F, 32'hFFFF_FFFF);
    check("t3_b2b_accept", 32'(busy), 32'h1);
    wait1(lat);
    check("t3_b2b_spacing", 32'(cyc - done_a), 32'd163);
    check("t3b_data", rdata, 32'hFFFF_FFFF);
    check("t3b_row_held", 32'(row_bad), 32'd0);

    // 4: reset in the middle of bit 17
    start1(7'h33, 32'h8000_0001);
    for (int i = 0; i < 200 && strobes <= 17; i++) @(negedge clk);
    check("t4_reached_bit17", 32'(strobes), 32'd18);
    d0 = dones;
    #2 arst_l = 1'b0;
    #1;
    check("t4_rst_data", rdata, 32'h0);
    check("t4_rst_rowcol", {20'h0, row, col}, 32'h0);
    check("t4_rst_flags", {28'h0, busy, done, ovfl, rd_en}, 32'h0);
    repeat (3) @(negedge clk);
    arst_l = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_no_done", 32'(dones - d0), 32'd0);
    start1(7'h0A, 32'h0000_0C30);
    wait1(lat);
    check("t4_fresh_latency", 32'(lat), 32'd161);
    check("t4_fresh_data", rdata, 32'h0000_0C30);

    // 5: X on fuse_dout outside the sample cycle never leaks; word stable mid-read
    check("t5_no_x", 32'($isunknown(rdata)), 32'h0);
    check("t5_stable", 32'(chg), 32'd0);

    // 6: ACC_CYC=2 instance
    @(negedge clk);
    pat2 = 32'h5A5A_C3C3; rd_row2 = 7'h19; rd_req2 = 1'b1; strobes2 = 0; last_strobe2 = -1;
    @(posedge clk);
    #1;
    r2 = cyc; rd_req2 = 1'b0;
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done2) begin
        lat = cyc - r2;
        break;
      end
    end
    check("t6_latency", 32'(lat), 32'd97);
    check("t6_data", rdata2, 32'h5A5A_C3C3);
    check("t6_strobes", 32'(strobes2), 32'd32);
    check("t6_spacing", 32'(gap_bad), 32'd0);
    check("t6_row", 32'(row2), 32'h19);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
